// File: rtl/result_display.sv
// Binary-to-decimal result display: double-dabble conversion into a 4-digit multiplexed
// 7-segment display. Define SIGNED_DISPLAY_EN to show two's-complement values with a minus digit.
module result_display #(
  parameter int SCAN_W = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] result,
  input  logic       load,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       busy,
  output logic       valid
);

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  // Per-digit display codes: 0-9 are BCD digits, plus two symbols.
  localparam logic [3:0] CODE_MINUS = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  state_t            state_q, state_d;
  logic [7:0]        mag_q, mag_d;
  logic [11:0]       bcd_q, bcd_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        units_q, units_d;
  logic [3:0]        tens_q, tens_d;
  logic [3:0]        hund_q, hund_d;
  logic [3:0]        sign_q, sign_d;
  logic              valid_q, valid_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
`ifdef SIGNED_DISPLAY_EN
  logic              neg_q, neg_d;
`endif

  function automatic logic [3:0] dabble_nibble(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] code);
    case (code)
      4'd0:       return 7'b1000000;
      4'd1:       return 7'b1111001;
      4'd2:       return 7'b0100100;
      4'd3:       return 7'b0110000;
      4'd4:       return 7'b0011001;
      4'd5:       return 7'b0010010;
      4'd6:       return 7'b0000010;
      4'd7:       return 7'b1111000;
      4'd8:       return 7'b0000000;
      4'd9:       return 7'b0010000;
      CODE_MINUS: return 7'b0111111;
      default:    return 7'b1111111;
    endcase
  endfunction

  // State register and all datapath flops.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      units_q <= CODE_BLANK;
      tens_q  <= CODE_BLANK;
      hund_q  <= CODE_BLANK;
      sign_q  <= CODE_BLANK;
      valid_q <= 1'b0;
      scan_q  <= '0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
`ifdef SIGNED_DISPLAY_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      units_q <= units_d;
      tens_q  <= tens_d;
      hund_q  <= hund_d;
      sign_q  <= sign_d;
      valid_q <= valid_d;
      scan_q  <= scan_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
`ifdef SIGNED_DISPLAY_EN
      neg_q   <= neg_d;
`endif
    end
  end

  // Next-state logic; load is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = CONVERT;
      CONVERT: if (cnt_q == 3'd7) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  // Conversion datapath and display-register update.
  always_comb begin
    logic [11:0] adj;
    // NOTE: every comb output gets a default first so no path can infer a latch.
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    units_d = units_q;
    tens_d  = tens_q;
    hund_d  = hund_q;
    sign_d  = sign_q;
    valid_d = valid_q;
    adj     = {dabble_nibble(bcd_q[11:8]), dabble_nibble(bcd_q[7:4]), dabble_nibble(bcd_q[3:0])};
`ifdef SIGNED_DISPLAY_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
`ifdef SIGNED_DISPLAY_EN
          neg_d = result[7];
          mag_d = result[7] ? (~result + 8'd1) : result;
`else
          mag_d = result;
`endif
          bcd_d = '0;
          cnt_d = '0;
        end
      end
      CONVERT: begin
        {bcd_d, mag_d} = {adj[10:0], mag_q, 1'b0};
        cnt_d          = cnt_q + 3'd1;
      end
      UPDATE: begin
        units_d = bcd_q[3:0];
        tens_d  = (bcd_q[11:4] == 8'd0) ? CODE_BLANK : bcd_q[7:4];
        hund_d  = (bcd_q[11:8] == 4'd0) ? CODE_BLANK : bcd_q[11:8];
`ifdef SIGNED_DISPLAY_EN
        sign_d  = neg_q ? CODE_MINUS : CODE_BLANK;
`else
        sign_d  = CODE_BLANK;
`endif
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Digit scan: the top two counter bits pick which digit is lit.
  always_comb begin
    logic [1:0] sel;
    logic [3:0] code;
    scan_d = scan_q + SCAN_W'(1);
    sel    = scan_q[SCAN_W-1 -: 2];
    case (sel)
      2'd0:    code = units_q;
      2'd1:    code = tens_q;
      2'd2:    code = hund_q;
      default: code = sign_q;
    endcase
    an_d  = ~(4'b0001 << sel);
    seg_d = seg_of(code);
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display: scan sequencing, conversion latency, load rejection,
// reset abort and leading-zero blanking; a small SCAN_W keeps full scans short.
module tb_result_display;

  localparam int SCAN_W = 4;
  localparam int SCAN_CYCLES = 1 << SCAN_W;

  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] S_MINUS = 7'b0111111;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] result;
  logic       load;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy;
  logic       valid;

  int checks   = 0;
  int failures = 0;

  // What the display should currently be showing, indexed units/tens/hundreds/sign.
  logic [6:0] shown [0:3];
  logic       shown_valid;

  result_display #(.SCAN_W(SCAN_W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .result(result),
    .load  (load),
    .seg   (seg),
    .an    (an),
    .busy  (busy),
    .valid (valid)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic int digit_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [6:0] shown_seg(input logic [3:0] a);
    int d = digit_of(a);
    return (d < 4) ? shown[d] : 7'h55;
  endfunction

  task automatic set_shown(input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3);
    shown[0] = s0; shown[1] = s1; shown[2] = s2; shown[3] = s3;
  endtask

  // Watch one full scan (plus margin) and compare each digit against 'shown'.
  task automatic read_display(input string tag);
    logic [6:0] got [0:3];
    int bad_an = 0;
    for (int d = 0; d < 4; d++) got[d] = 7'h55;
    for (int i = 0; i < SCAN_CYCLES + 4; i++) begin
      int d = digit_of(an);
      if (d < 4) got[d] = seg; else bad_an++;
      step();
    end
    check({tag, "_units"}, got[0], shown[0]);
    check({tag, "_tens"},  got[1], shown[1]);
    check({tag, "_hund"},  got[2], shown[2]);
    check({tag, "_sign"},  got[3], shown[3]);
    check({tag, "_an_onehot"}, bad_an, 0);
  endtask

  // Load v at edge N; optionally present a second load sampled at edge N+3.
  // Checks busy for 9 cycles, held display during conversion, and valid at N+9.
  task automatic do_load(input string tag, input logic [7:0] v,
                         input bit second, input logic [7:0] v2);
    int held_bad = 0;
    result = v;
    load   = 1'b1;
    step();                       // edge N
    load   = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check({tag, "_busy"}, busy, 1'b1);
      if (valid !== shown_valid) held_bad++;
      if (seg !== shown_seg(an)) held_bad++;
      if (second && i == 2) begin
        result = v2;
        load   = 1'b1;
      end else begin
        load   = 1'b0;
      end
      step();
    end
    check({tag, "_held"},  held_bad, 0);
    check({tag, "_done_busy"},  busy,  1'b0);
    check({tag, "_done_valid"}, valid, 1'b1);
    shown_valid = 1'b1;
  endtask

  initial begin
    Reset  = 1'b1;
    load   = 1'b0;
    result = 8'd0;
    set_shown(S_BLANK, S_BLANK, S_BLANK, S_BLANK);
    shown_valid = 1'b0;

    #2;
    check("rst_an",    an,    4'b1111);
    check("rst_seg",   seg,   S_BLANK);
    check("rst_busy",  busy,  1'b0);
    check("rst_valid", valid, 1'b0);
    step();
    step();
    Reset = 1'b0;

    // Two full scans with no load: digits cycle 0..3, all blank, not valid.
    begin
      int scan_bad = 0;
      for (int k = 1; k <= 2 * SCAN_CYCLES; k++) begin
        logic [3:0] exp_an;
        step();
        exp_an = ~(4'b0001 << (((k - 1) >> 2) & 3));
        if (k == 1) check("scan_first_an", an, 4'b1110);
        if (an !== exp_an || seg !== S_BLANK || valid !== 1'b0) scan_bad++;
      end
      check("scan_idle_errors", scan_bad, 0);
    end

    do_load("ld42", 8'd42, 1'b0, 8'd0);
    set_shown(S2, S4, S_BLANK, S_BLANK);
    read_display("d42");

    do_load("ld80", 8'h80, 1'b0, 8'd0);
`ifdef SIGNED_DISPLAY_EN
    set_shown(S8, S2, S1, S_MINUS);
`else
    set_shown(S8, S2, S1, S_BLANK);
`endif
    read_display("d80");

    do_load("ld7", 8'd7, 1'b1, 8'd200);
    set_shown(S7, S_BLANK, S_BLANK, S_BLANK);
    check("ld7_no_requeue_busy", busy, 1'b0);
    read_display("d7");

    do_load("ld200", 8'd200, 1'b0, 8'd0);
    set_shown(S0, S0, S2, S_BLANK);
    read_display("d200");

    // Reset part-way through a conversion aborts it.
    result = 8'd255;
    load   = 1'b1;
    step();                       // edge N
    load   = 1'b0;
    for (int i = 0; i < 3; i++) step();
    Reset = 1'b1;
    #1;
    check("abort_an",    an,    4'b1111);
    check("abort_seg",   seg,   S_BLANK);
    check("abort_busy",  busy,  1'b0);
    check("abort_valid", valid, 1'b0);
    step();
    step();
    Reset = 1'b0;
    set_shown(S_BLANK, S_BLANK, S_BLANK, S_BLANK);
    shown_valid = 1'b0;
    step();
    check("abort_resume_an", an, 4'b1110);
    for (int i = 0; i < 12; i++) step();
    check("abort_post_busy",  busy,  1'b0);
    check("abort_post_valid", valid, 1'b0);
    read_display("dabort");

    do_load("ld0", 8'd0, 1'b0, 8'd0);
    set_shown(S0, S_BLANK, S_BLANK, S_BLANK);
    read_display("d0");

    do_load("ld105", 8'd105, 1'b0, 8'd0);
    set_shown(S5, S0, S1, S_BLANK);
    read_display("d105");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
